// File: rtl/nf_rf_pkg.sv
// Shared types and helpers for the nanoFOX register file with load scoreboard.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package nf_rf_pkg;

    // Top-level sequencer state: zeroing sweep after reset, then normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    // A register address is usable only when it is nonzero (x0 is hardwired)
    // and inside the implemented register count (REG_N need not be a power of 2).
    function automatic logic rf_addr_ok(input logic [31:0] addr, input logic [31:0] reg_n);
        return (addr != 32'd0) && (addr < reg_n);
    endfunction

endpackage

// File: rtl/nf_rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on load writeback.
// Latency: set/clear take effect next cycle; busy flags see a same-cycle clear when BYPASS=1.
// Backpressure: none; lock and clear requests are accepted every RUN cycle and ignored otherwise.
module nf_rf_scoreboard
    import nf_rf_pkg::*;
#(
    parameter int REG_N  = 32,
    parameter int AW     = $clog2(REG_N),
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic          lock_en,
    input  logic [AW-1:0] lock_addr,
    input  logic          we_b,
    input  logic [AW-1:0] wa_b,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic          any_pend
);

    logic [REG_N-1:0] pend;
    logic             set_ok;
    logic             clr_ok;
    logic             ra1_ok;
    logic             ra2_ok;
    logic             byp_clr1;
    logic             byp_clr2;

    assign set_ok = run && lock_en && rf_addr_ok(32'(lock_addr), 32'(REG_N));
    assign clr_ok = run && we_b && rf_addr_ok(32'(wa_b), 32'(REG_N));
    assign ra1_ok = rf_addr_ok(32'(ra1), 32'(REG_N));
    assign ra2_ok = rf_addr_ok(32'(ra2), 32'(REG_N));

    // A load returning this cycle already satisfies a reader of the same register.
    assign byp_clr1 = (BYPASS != 0) && we_b && (wa_b == ra1);
    assign byp_clr2 = (BYPASS != 0) && we_b && (wa_b == ra2);

    // Pending bits: clear first, then set, so a same-address set overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else begin
            if (clr_ok) begin
                pend[wa_b] <= 1'b0;
            end
            if (set_ok) begin
                pend[lock_addr] <= 1'b1;
            end
        end
    end

    // Busy flags to the hazard unit; x0 and out-of-range addresses are never busy.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (run && ra1_ok) begin
            busy1 = pend[ra1] && !byp_clr1;
        end
        if (run && ra2_ok) begin
            busy2 = pend[ra2] && !byp_clr2;
        end
    end

    assign any_pend = |pend;

endmodule

// File: rtl/nf_reg_file_sb.sv
// Register file: x0 hardwired, ALU + load write ports, optional bypass, load scoreboard, post-reset zero sweep.
// Latency: reads combinational; writes visible next cycle (same cycle when BYPASS=1); ready after REG_N cycles.
// Backpressure: none; writes and locks are dropped while the clear sweep runs (ready=0).
module nf_reg_file_sb
    import nf_rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_N  = 32,
    parameter int AW     = $clog2(REG_N),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   ra0,
    output logic [XLEN-1:0] rd0,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we_a,
    input  logic [AW-1:0]   wa_a,
    input  logic [XLEN-1:0] wd_a,
    input  logic            we_b,
    input  logic [AW-1:0]   wa_b,
    input  logic [XLEN-1:0] wd_b,
    input  logic            lock_en,
    input  logic [AW-1:0]   lock_addr,
    output logic            any_pend,
    output logic            ready
);

    rf_state_t       state;
    logic [AW-1:0]   clr_cnt;
    logic            run;
    logic            wr_a_ok;
    logic            wr_b_ok;
    logic [XLEN-1:0] regs [REG_N];
    logic [AW-1:0]   ra_v [3];
    logic [XLEN-1:0] rd_v [3];

    assign run     = (state == RUN);
    assign wr_a_ok = we_a && rf_addr_ok(32'(wa_a), 32'(REG_N));
    assign wr_b_ok = we_b && rf_addr_ok(32'(wa_b), 32'(REG_N));

    // Clear sequencer: sweep clr_cnt over every register once, then stay in RUN until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == AW'(REG_N - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zeroed by the sweep rather than by reset; port A is written last so it wins a tie.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[clr_cnt] <= '0;
        end else begin
            if (wr_b_ok) begin
                regs[wa_b] <= wd_b;
            end
            if (wr_a_ok) begin
                regs[wa_a] <= wd_a;
            end
        end
    end

    assign ra_v[0] = ra0;
    assign ra_v[1] = ra1;
    assign ra_v[2] = ra2;

    // Read muxes: x0 / out of range / sweeping read as zero; otherwise bypass (A over B) or stored value.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_v[p] = '0;
            if (run && rf_addr_ok(32'(ra_v[p]), 32'(REG_N))) begin
                if ((BYPASS != 0) && we_a && (wa_a == ra_v[p])) begin
                    rd_v[p] = wd_a;
                end else if ((BYPASS != 0) && we_b && (wa_b == ra_v[p])) begin
                    rd_v[p] = wd_b;
                end else begin
                    rd_v[p] = regs[ra_v[p]];
                end
            end
        end
    end

    assign rd0 = rd_v[0];
    assign rd1 = rd_v[1];
    assign rd2 = rd_v[2];

    nf_rf_scoreboard #(
        .REG_N  (REG_N),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .we_b      (we_b),
        .wa_b      (wa_b),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .any_pend  (any_pend)
    );

endmodule

// File: tb/tb_nf_reg_file_sb.sv
// Bench for nf_reg_file_sb: three instances (32 regs bypass, 32 regs no bypass, 20 regs bypass).
// Latency: outputs sampled mid-cycle against a behavioural model updated at each rising edge.
// Backpressure: n/a.
module tb_nf_reg_file_sb;

    localparam int NI     = 3;
    localparam int NS[NI] = '{32, 32, 20};
    localparam int BS[NI] = '{1, 0, 1};

    logic        clk;
    logic        resetn;
    logic [4:0]  ra0, ra1, ra2;
    logic        we_a, we_b, lock_en;
    logic [4:0]  wa_a, wa_b, lock_addr;
    logic [31:0] wd_a, wd_b;

    logic [NI-1:0][31:0] rd0_o, rd1_o, rd2_o;
    logic [NI-1:0]       busy1_o, busy2_o, any_pend_o, ready_o;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model, one copy per instance
    logic [31:0] m_regs [NI][32];
    logic [31:0] m_pend [NI];
    bit          m_ready [NI];
    int          m_cyc [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        nf_reg_file_sb #(
            .XLEN   (32),
            .REG_N  (NS[g]),
            .BYPASS (BS[g])
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .ra0       (ra0),
            .rd0       (rd0_o[g]),
            .ra1       (ra1),
            .rd1       (rd1_o[g]),
            .ra2       (ra2),
            .rd2       (rd2_o[g]),
            .busy1     (busy1_o[g]),
            .busy2     (busy2_o[g]),
            .we_a      (we_a),
            .wa_a      (wa_a),
            .wd_a      (wd_a),
            .we_b      (we_b),
            .wa_b      (wa_b),
            .wd_b      (wd_b),
            .lock_en   (lock_en),
            .lock_addr (lock_addr),
            .any_pend  (any_pend_o[g]),
            .ready     (ready_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input int i, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NS[i]);
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] ra);
        if (!m_ready[i] || !addr_ok(i, ra)) return 32'd0;
        if (BS[i] != 0 && we_a && wa_a == ra) return wd_a;
        if (BS[i] != 0 && we_b && wa_b == ra) return wd_b;
        return m_regs[i][ra];
    endfunction

    function automatic logic [31:0] exp_busy(input int i, input logic [4:0] ra);
        if (!m_ready[i] || !addr_ok(i, ra)) return 32'd0;
        if (BS[i] != 0 && we_b && wa_b == ra) return 32'd0;
        return 32'(m_pend[i][ra]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_ready[i] = 1'b0;
            m_cyc[i]   = 0;
            m_pend[i]  = '0;
        end
    endtask

    // One rising edge of the model: the register file becomes all-zero and usable REG_N edges after release.
    task automatic model_edge();
        if (!resetn) return;
        for (int i = 0; i < NI; i++) begin
            if (m_ready[i]) begin
                if (we_b && addr_ok(i, wa_b)) begin
                    m_regs[i][wa_b] = wd_b;
                    m_pend[i][wa_b] = 1'b0;
                end
                if (we_a && addr_ok(i, wa_a)) m_regs[i][wa_a] = wd_a;
                if (lock_en && addr_ok(i, lock_addr)) m_pend[i][lock_addr] = 1'b1;
            end else begin
                m_cyc[i]++;
                if (m_cyc[i] == NS[i]) begin
                    m_ready[i] = 1'b1;
                    for (int r = 0; r < 32; r++) m_regs[i][r] = 32'd0;
                end
            end
        end
    endtask

    task automatic idle();
        ra0 = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
        we_a = 1'b0; wa_a = 5'd0; wd_a = 32'd0;
        we_b = 1'b0; wa_b = 5'd0; wd_b = 32'd0;
        lock_en = 1'b0; lock_addr = 5'd0;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(3) == 0) return 5'($urandom_range(7));
        return 5'($urandom_range(31));
    endfunction

    task automatic rand_inputs();
        ra0 = raddr(); ra1 = raddr(); ra2 = raddr();
        we_a = 1'($urandom_range(1)); wa_a = raddr(); wd_a = $urandom;
        we_b = 1'($urandom_range(1)); wa_b = raddr(); wd_b = $urandom;
        lock_en = ($urandom_range(9) < 3); lock_addr = raddr();
    endtask

    // Mid-cycle: compare every output of every instance with the model.
    task automatic settle();
        #4;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.ready", i), 32'(ready_o[i]), 32'(m_ready[i]));
            chk($sformatf("u%0d.rd0", i), rd0_o[i], exp_rd(i, ra0));
            chk($sformatf("u%0d.rd1", i), rd1_o[i], exp_rd(i, ra1));
            chk($sformatf("u%0d.rd2", i), rd2_o[i], exp_rd(i, ra2));
            chk($sformatf("u%0d.busy1", i), 32'(busy1_o[i]), exp_busy(i, ra1));
            chk($sformatf("u%0d.busy2", i), 32'(busy2_o[i]), exp_busy(i, ra2));
            chk($sformatf("u%0d.any_pend", i), 32'(any_pend_o[i]), 32'(m_ready[i] && (m_pend[i] != 0)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_cycle();
        settle();
        tick();
    endtask

    task automatic sweep_zero_check(input string tag);
        idle();
        for (int a = 1; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'($urandom_range(31));
            settle();
            chk(tag, rd1_o[0], 32'd0);
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++)
            for (int r = 0; r < 32; r++) m_regs[i][r] = 32'd0;
        idle();
        resetn = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // held in reset, then a partial sweep interrupted at cycle 10
        repeat (2) begin rand_inputs(); do_cycle(); end
        resetn = 1'b1;
        repeat (10) begin rand_inputs(); do_cycle(); end
        resetn = 1'b0;
        model_reset();
        repeat (2) begin rand_inputs(); do_cycle(); end
        resetn = 1'b1;

        // full sweep with random (ignored) traffic; ready must rise at exactly REG_N edges
        for (int c = 1; c <= 32; c++) begin
            rand_inputs();
            settle();
            if (c == 20) chk("ready_early_u0", 32'(ready_o[0]), 32'd0);
            tick();
        end
        sweep_zero_check("clr_zero");

        // same-cycle bypass vs registered visibility
        idle(); we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; ra1 = 5'd5;
        settle();
        chk("byp_same", rd1_o[0], 32'hDEADBEEF);
        chk("nobyp_same", rd1_o[1], 32'd0);
        tick();
        idle(); ra1 = 5'd5;
        settle();
        chk("nobyp_next", rd1_o[1], 32'hDEADBEEF);
        tick();

        // write-port collision (A wins) and x0 write
        idle(); we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1; we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h2;
        do_cycle();
        idle(); we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF; ra1 = 5'd7; ra2 = 5'd0;
        settle();
        chk("a_wins", rd1_o[1], 32'h1);
        tick();
        idle(); ra1 = 5'd0;
        settle();
        chk("x0_zero", rd1_o[0], 32'd0);
        tick();

        // lock, then load writeback releases it
        idle(); lock_en = 1'b1; lock_addr = 5'd9; ra1 = 5'd9;
        do_cycle();
        idle(); ra1 = 5'd9;
        settle();
        chk("lock_busy", 32'(busy1_o[0]), 32'd1);
        chk("lock_any", 32'(any_pend_o[0]), 32'd1);
        tick();
        idle(); we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h99; ra1 = 5'd9;
        settle();
        chk("wb_byp_busy", 32'(busy1_o[0]), 32'd0);
        chk("wb_nobyp_busy", 32'(busy1_o[1]), 32'd1);
        tick();
        idle(); ra1 = 5'd9;
        settle();
        chk("wb_cleared", 32'(busy1_o[1]), 32'd0);
        chk("wb_any", 32'(any_pend_o[0]), 32'd0);
        tick();

        // set and clear to the same register in one cycle: set wins, data lands
        idle(); lock_en = 1'b1; lock_addr = 5'd3; we_b = 1'b1; wa_b = 5'd3; wd_b = 32'hCAFE0003;
        do_cycle();
        idle(); ra1 = 5'd3;
        settle();
        chk("set_wins", 32'(busy1_o[1]), 32'd1);
        chk("set_wins_data", rd1_o[1], 32'hCAFE0003);
        tick();

        // random traffic
        repeat (1500) begin rand_inputs(); do_cycle(); end

        // reset from RUN: the sweep must wipe everything written above
        resetn = 1'b0;
        model_reset();
        rand_inputs();
        do_cycle();
        resetn = 1'b1;
        repeat (32) begin rand_inputs(); do_cycle(); end
        sweep_zero_check("reclr_zero");
        repeat (300) begin rand_inputs(); do_cycle(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
